// File: rtl/prog_loader.sv
// Host-side instruction memory loader: receives a length-prefixed byte stream,
// writes 9-bit instructions to ROM from address 0, starts the core and times the run.
module prog_loader #(
  parameter int PC_WIDTH   = 11,
  parameter int INST_WIDTH = 9,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_req,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  rom_we,
  output logic [PC_WIDTH-1:0]   rom_addr,
  output logic [INST_WIDTH-1:0] rom_wdata,
  output logic                  start,
  input  logic                  done,
  output logic                  busy,
  output logic                  run_done,
  output logic                  error,
  output logic [CNT_WIDTH-1:0]  cycle_count
);

  localparam int CW      = PC_WIDTH + 1;
  localparam int MAX_LEN = 2 ** PC_WIDTH;

  typedef enum logic [3:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    INST_LO,
    INST_HI,
    WRITE,
    START,
    RUN,
    FINISH,
    ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           length_q, length_d;
  logic [7:0]            word_lo_q, word_lo_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CNT_WIDTH-1:0]  cycle_count_q, cycle_count_d;
  logic [PC_WIDTH-1:0]   rom_addr_q, rom_addr_d;
  logic [INST_WIDTH-1:0] rom_wdata_q, rom_wdata_d;
  logic                  byte_ready_q, byte_ready_d;
  logic                  rom_we_q, rom_we_d;
  logic                  start_q, start_d;
  logic                  busy_q, busy_d;
  logic                  run_done_q, run_done_d;
  logic                  error_q, error_d;

  logic                  xfer;
  logic [15:0]           len_new;
  logic [CW-1:0]         cnt_next;

  // The counter is one bit wider than the address so a full ROM load reaches 2**PC_WIDTH.
  assign xfer     = byte_valid & byte_ready_q;
  assign len_new  = {byte_in, length_q[7:0]};
  assign cnt_next = count_q + CW'(1);

  always_comb begin
    state_d       = state_q;
    length_d      = length_q;
    word_lo_d     = word_lo_q;
    count_d       = count_q;
    cycle_count_d = cycle_count_q;
    rom_addr_d    = rom_addr_q;
    rom_wdata_d   = rom_wdata_q;

    case (state_q)
      IDLE: begin
        if (load_req) begin
          state_d       = LEN_LO;
          count_d       = '0;
          cycle_count_d = '0;
        end
      end
      LEN_LO: begin
        if (xfer) begin
          length_d[7:0] = byte_in;
          state_d       = LEN_HI;
        end
      end
      LEN_HI: begin
        if (xfer) begin
          length_d[15:8] = byte_in;
          if ((len_new == 16'd0) || (32'(len_new) > 32'(MAX_LEN))) begin
            state_d = ERROR;
          end else begin
            state_d = INST_LO;
          end
        end
      end
      INST_LO: begin
        if (xfer) begin
          word_lo_d = byte_in;
          state_d   = INST_HI;
        end
      end
      INST_HI: begin
        if (xfer) begin
          if (byte_in[7:1] != 7'd0) begin
            state_d = ERROR;
          end else begin
            state_d     = WRITE;
            rom_addr_d  = count_q[PC_WIDTH-1:0];
            rom_wdata_d = INST_WIDTH'({byte_in[0], word_lo_q});
          end
        end
      end
      WRITE: begin
        count_d = cnt_next;
        if (32'(cnt_next) == 32'(length_q)) begin
          state_d = START;
        end else begin
          state_d = INST_LO;
        end
      end
      START: begin
        cycle_count_d = '0;
        state_d       = RUN;
      end
      RUN: begin
        // The cycle in which done is observed is deliberately not counted.
        if (done) begin
          state_d = FINISH;
        end else if (cycle_count_q != {CNT_WIDTH{1'b1}}) begin
          cycle_count_d = cycle_count_q + CNT_WIDTH'(1);
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      ERROR: begin
        if (load_req) begin
          state_d       = LEN_LO;
          count_d       = '0;
          cycle_count_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobes are registered from the next state so no input reaches an output combinationally.
  always_comb begin
    byte_ready_d = (state_d == LEN_LO) || (state_d == LEN_HI) ||
                   (state_d == INST_LO) || (state_d == INST_HI);
    rom_we_d     = (state_d == WRITE);
    start_d      = (state_d == START);
    run_done_d   = (state_d == FINISH);
    error_d      = (state_d == ERROR);
    busy_d       = (state_d != IDLE) && (state_d != ERROR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      length_q      <= '0;
      word_lo_q     <= '0;
      count_q       <= '0;
      cycle_count_q <= '0;
      rom_addr_q    <= '0;
      rom_wdata_q   <= '0;
      byte_ready_q  <= 1'b0;
      rom_we_q      <= 1'b0;
      start_q       <= 1'b0;
      busy_q        <= 1'b0;
      run_done_q    <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      length_q      <= length_d;
      word_lo_q     <= word_lo_d;
      count_q       <= count_d;
      cycle_count_q <= cycle_count_d;
      rom_addr_q    <= rom_addr_d;
      rom_wdata_q   <= rom_wdata_d;
      byte_ready_q  <= byte_ready_d;
      rom_we_q      <= rom_we_d;
      start_q       <= start_d;
      busy_q        <= busy_d;
      run_done_q    <= run_done_d;
      error_q       <= error_d;
    end
  end

  assign byte_ready  = byte_ready_q;
  assign rom_we      = rom_we_q;
  assign rom_addr    = rom_addr_q;
  assign rom_wdata   = rom_wdata_q;
  assign start       = start_q;
  assign busy        = busy_q;
  assign run_done    = run_done_q;
  assign error       = error_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: a byte-stream reference model queues expected
// ROM writes, start, run results and errors; a negedge monitor pops and compares.
module tb_prog_loader;

  localparam int PC_WIDTH   = 11;
  localparam int INST_WIDTH = 9;
  localparam int CNT_WIDTH  = 16;
  localparam int MAX_LEN    = 2 ** PC_WIDTH;

  localparam int EV_WRITE = 0;
  localparam int EV_START = 1;
  localparam int EV_RUN   = 2;
  localparam int EV_ERROR = 3;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  load_req = 1'b0;
  logic [7:0]            byte_in = 8'd0;
  logic                  byte_valid = 1'b0;
  logic                  done = 1'b0;
  logic                  byte_ready;
  logic                  rom_we;
  logic [PC_WIDTH-1:0]   rom_addr;
  logic [INST_WIDTH-1:0] rom_wdata;
  logic                  start;
  logic                  busy;
  logic                  run_done;
  logic                  error;
  logic [CNT_WIDTH-1:0]  cycle_count;

  typedef struct {
    int kind;
    int addr;
    int data;
  } ev_t;

  ev_t  exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   last_we = -100;
  logic err_prev = 1'b0;
  bit   mon_en = 1'b0;

  prog_loader #(
    .PC_WIDTH  (PC_WIDTH),
    .INST_WIDTH(INST_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_req   (load_req),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .rom_we     (rom_we),
    .rom_addr   (rom_addr),
    .rom_wdata  (rom_wdata),
    .start      (start),
    .done       (done),
    .busy       (busy),
    .run_done   (run_done),
    .error      (error),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic note_fail(input string name);
    checks++;
    $display("[TB] FAIL %s: got no response, expected one", name);
  endtask

  // Expected behaviour derived from the stream format alone: header, then lo/hi pairs.
  function automatic int ref_model(input logic [7:0] s[$], input int run_n, output bit ok);
    int len;
    len = int'(s[0]) + 256 * int'(s[1]);
    ok  = 1'b0;
    if (len == 0 || len > MAX_LEN) begin
      exp_q.push_back('{EV_ERROR, 0, 0});
      return 2;
    end
    for (int i = 0; i < len; i++) begin
      int lo;
      int hi;
      lo = int'(s[2 + 2 * i]);
      hi = int'(s[3 + 2 * i]);
      if (hi > 1) begin
        exp_q.push_back('{EV_ERROR, 0, 0});
        return 4 + 2 * i;
      end
      exp_q.push_back('{EV_WRITE, i, hi * 256 + lo});
    end
    ok = 1'b1;
    exp_q.push_back('{EV_START, 0, 0});
    exp_q.push_back('{EV_RUN, run_n > 65535 ? 65535 : run_n, 0});
    return 2 + 2 * len;
  endfunction

  task automatic pop_cmp(input int kind, input int a);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      $display("[TB] FAIL unexpected_event: got kind %0d value 0x%0h, expected nothing", kind, a);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      if (kind == e.kind && kind == EV_WRITE) check("write_addr", a, e.addr);
      if (kind == e.kind && kind == EV_RUN) check("run_cycle_count", a, e.addr);
    end
  endtask

  task automatic pop_write(input int a, input int d);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected nothing", a, d);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", EV_WRITE, e.kind);
      if (e.kind == EV_WRITE) begin
        check("write_addr", a, e.addr);
        check("write_data", d, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (rom_we) begin
        pop_write(int'(rom_addr), int'(rom_wdata));
        last_we = cyc;
      end
      if (start) begin
        pop_cmp(EV_START, 0);
        check("start_after_write", cyc - last_we, 1);
      end
      if (run_done) pop_cmp(EV_RUN, int'(cycle_count));
      if (error && !err_prev) pop_cmp(EV_ERROR, 0);
    end
    err_prev = error;
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    @(posedge clk);
    #1;
    byte_in    = b;
    byte_valid = 1'b1;
    @(negedge clk);
    while (!byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready) note_fail("byte_ready_timeout");
    else begin
      @(posedge clk);
      #1;
    end
    byte_valid = 1'b0;
    byte_in    = 8'($urandom);
  endtask

  task automatic stall5();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_ready", int'(byte_ready), 1);
      check("stall_busy", int'(busy), 1);
      load_req = (k == 2);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_byte_ready"}, int'(byte_ready), 0);
    check({tag, "_rom_we"}, int'(rom_we), 0);
    check({tag, "_rom_addr"}, int'(rom_addr), 0);
    check({tag, "_rom_wdata"}, int'(rom_wdata), 0);
    check({tag, "_start"}, int'(start), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_run_done"}, int'(run_done), 0);
    check({tag, "_error"}, int'(error), 0);
    check({tag, "_cycle_count"}, int'(cycle_count), 0);
  endtask

  task automatic apply_stimulus(input logic [7:0] s[$], input bit stall, input int run_n,
                                input bit done_in_start);
    int n;
    int t;
    bit ok;
    n = ref_model(s, run_n, ok);
    @(negedge clk) load_req = 1'b1;
    @(negedge clk) load_req = 1'b0;
    check("load_error_clear", int'(error), 0);
    check("load_busy", int'(busy), 1);
    check("load_ready", int'(byte_ready), 1);
    for (int i = 0; i < n; i++) begin
      send_byte(s[i]);
      if (stall && i >= 2 && (i % 2) == 0 && i < n - 1) stall5();
    end
    if (ok) begin
      t = 0;
      @(negedge clk);
      while (!start && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (!start) note_fail("start_timeout");
      done = done_in_start;
      @(posedge clk);
      #1 done = 1'b0;
      repeat (run_n) @(posedge clk);
      #1 done = 1'b1;
      t = 0;
      @(negedge clk);
      while (!run_done && t < run_n + 40) begin
        @(negedge clk);
        t++;
      end
      if (!run_done) note_fail("run_done_timeout");
      done = 1'b0;
      @(negedge clk);
      check("run_done_one_cycle", int'(run_done), 0);
      check("idle_busy", int'(busy), 0);
      check("count_held", int'(cycle_count), run_n);
    end else begin
      repeat (3) @(negedge clk);
      check("err_sticky", int'(error), 1);
      check("err_ready", int'(byte_ready), 0);
      check("err_busy", int'(busy), 0);
    end
    check("queue_drain", exp_q.size(), 0);
  endtask

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] s[$];
    int len;
    int bad_pos;
    bit bad;

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset  = 1'b1;
    mon_en = 1'b1;

    $display("[TB] normal load");
    s = '{8'h03, 8'h00, 8'h12, 8'h01, 8'h34, 8'h00, 8'hFF, 8'h01};
    apply_stimulus(s, 1'b0, 10, 1'b0);

    $display("[TB] backpressure load");
    apply_stimulus(s, 1'b1, 7, 1'b1);

    $display("[TB] length errors");
    s = '{8'h00, 8'h00};
    apply_stimulus(s, 1'b0, 0, 1'b0);
    s = '{8'h01, 8'h08};
    apply_stimulus(s, 1'b0, 0, 1'b0);

    $display("[TB] format error");
    s = '{8'h02, 8'h00, 8'h11, 8'h00, 8'h55, 8'h02};
    apply_stimulus(s, 1'b0, 0, 1'b0);

    $display("[TB] random sessions");
    for (int r = 0; r < 8; r++) begin
      len     = $urandom_range(1, 24);
      bad     = ($urandom_range(0, 3) == 0);
      bad_pos = $urandom_range(0, len - 1);
      s = {};
      s.push_back(8'(len));
      s.push_back(8'(len >> 8));
      for (int i = 0; i < len; i++) begin
        s.push_back(8'($urandom));
        if (bad && i == bad_pos) s.push_back(8'($urandom_range(2, 255)));
        else s.push_back(8'($urandom_range(0, 1)));
      end
      apply_stimulus(s, 1'($urandom_range(0, 1)), $urandom_range(0, 40),
                     1'($urandom_range(0, 1)));
    end
    len = $urandom_range(MAX_LEN + 1, 65535);
    s = '{8'(len), 8'(len >> 8)};
    apply_stimulus(s, 1'b0, 0, 1'b0);

    $display("[TB] full ROM");
    s = '{8'h00, 8'h08};
    for (int i = 0; i < MAX_LEN; i++) begin
      s.push_back(8'($urandom));
      s.push_back(8'($urandom_range(0, 1)));
    end
    apply_stimulus(s, 1'b0, 5, 1'b0);

    $display("[TB] mid-session reset");
    exp_q.push_back('{EV_WRITE, 0, 9'h0AB});
    @(negedge clk) load_req = 1'b1;
    @(negedge clk) load_req = 1'b0;
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'hAB);
    send_byte(8'h00);
    send_byte(8'h5C);
    #2 reset = 1'b0;
    #1 check_all_zero("mid_reset");
    repeat (4) @(negedge clk);
    check("reset_queue_drain", exp_q.size(), 0);
    reset = 1'b1;
    s = '{8'h03, 8'h00, 8'h12, 8'h01, 8'h34, 8'h00, 8'hFF, 8'h01};
    apply_stimulus(s, 1'b0, 3, 1'b0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
